dram_request_arbiter: RTL and testbench
=======================================

Name: dram_request_arbiter

Overview:
- Memory-side responder that lets the four matrix-multiplier cores share one single-port DRAM.
- Accepts independent read/write requests from cores 0-3, grants one at a time in round-robin order, and drives the DRAM.
- Returns a one-cycle acknowledge to the granted core, with read data where applicable.
- Replaces lockstep broadcast servicing, so cores may issue unaligned accesses.

Parameters:
- ADDR_W, 16, DRAM address width per core.
- DATA_W, 8, data width.
- RD_LAT, 1, DRAM read latency in cycles from rden-asserted cycle to q valid (legal 1..4).

Ports:
- i_clk  in  1  system clock (the divided core clock).
- i_rst  in  1  reset, asynchronous, active-high.
- i_req  in  4  per-core request; bit n = core n; held high with stable addr/data/we until ack.
- i_we  in  4  per-core 1=write, 0=read; valid while i_req[n].
- i_addr  in  4*ADDR_W  packed addresses, core n at [n*ADDR_W +: ADDR_W].
- i_wdata  in  4*DATA_W  packed write data, core n at [n*DATA_W +: DATA_W].
- o_ack  out  4  one-cycle completion pulse to granted core.
- o_rdata  out  DATA_W  read data; valid in ack cycle of a read; held until next read completes.
- o_mem_addr  out  ADDR_W  DRAM address.
- o_mem_data  out  DATA_W  DRAM write data.
- o_mem_rden  out  1  DRAM read enable.
- o_mem_wren  out  1  DRAM write enable.
- i_mem_q  in  DATA_W  DRAM read data.
- o_busy  out  1  high whenever FSM not IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; o_ack=0; o_mem_rden=o_mem_wren=0; o_mem_addr=0; o_mem_data=0; o_rdata=0; o_busy=0; last_grant=3, so core 0 has first priority.
- All outputs registered.
- FSM states and transitions:
  - IDLE: if any i_req, select grant g = first requesting core scanning from last_grant+1 upward modulo 4. Latch addr/wdata/we of g. Go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): o_mem_addr/o_mem_data = latched values; o_mem_wren=we, o_mem_rden=~we. Write goes to ACK; read goes to WAIT with counter=RD_LAT.
  - WAIT: strobes low, counter decrements each cycle. In the cycle counter==1, sample i_mem_q into o_rdata and go to ACK.
  - ACK (1 cycle): o_ack[g]=1, all other bits 0; last_grant=g; go to IDLE.
- Latency from the cycle IDLE sees the request to the ack cycle: write = 2 cycles; read = 2+RD_LAT cycles.
- Requester must drop i_req[g] the cycle after ack. IDLE re-samples requests then, so a registered requester never double-issues.
- Requests arriving during non-IDLE states wait; no request is dropped.
- A request deasserted before grant is simply not serviced; no error.
- Simultaneous requests: exactly one grant per transaction. Round robin guarantees each waiting core service within 4 transactions.
- o_mem_rden and o_mem_wren are never high together, and never high outside ISSUE.
- o_rdata unchanged by writes.
- Reset mid-transaction aborts it; no ack issued; the DRAM write may or may not have occurred.
- Address and data pass through unmodified; no width arithmetic.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest-numbered requesting core always wins; last_grant is unused.
- Undefined (default): round robin as above.
- Latency and handshake are identical in both modes.

Test Plan:
- Single write: i_req=4'b0001, we=1, addr=16'h0010, wdata=8'hA5. Response: wren pulse with addr 16'h0010 / data 8'hA5 one cycle later; o_ack=4'b0001 two cycles after request sampled; o_busy high 2 cycles.
- Single read, RD_LAT=1: model returns 8'h3C for addr 16'h0020, i_req=4'b0100, we=0. Response: rden one cycle; o_ack=4'b0100 three cycles after sample; o_rdata=8'h3C, held through following write.
- Contention: all four cores request reads simultaneously and hold until ack. Response: acks in order core0, 1, 2, 3; no two rden/wren overlap. With ARB_FIXED_PRIO_EN and core0 re-requesting immediately, core0 is served every transaction.
- Fairness: core2 just served, then i_req=4'b0101. Response: next grant core0 (scan 3, 0), then core2.
- RD_LAT=3 read: ack exactly 5 cycles after sample; o_rdata equals the model q sampled 3 cycles after rden.
- Reset during WAIT: assert i_rst asynchronously mid-cycle. Response: strobes, ack, busy 0 immediately; o_rdata=0. After release, pending core0 request is served first.

Source files
------------

// File: rtl/dram_request_arbiter.sv
// Shares one single-port DRAM among four cores and services one request at a time.
// Define ARB_FIXED_PRIO_EN to replace round robin with fixed priority (core 0 highest).
module dram_request_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_req,
    input  logic [3:0]            i_we,
    input  logic [4*ADDR_W-1:0]   i_addr,
    input  logic [4*DATA_W-1:0]   i_wdata,
    output logic [3:0]            o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_data,
    output logic                  o_mem_rden,
    output logic                  o_mem_wren,
    input  logic [DATA_W-1:0]     i_mem_q,
    output logic                  o_busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t              state_reg, state_next;
    logic [1:0]          grant_reg, grant_next;
    logic                we_reg, we_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [3:0]          ack_reg, ack_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
    logic                mem_rden_reg, mem_rden_next;
    logic                mem_wren_reg, mem_wren_next;
    logic                busy_reg, busy_next;

    logic [ADDR_W-1:0]   core_addr  [4];
    logic [DATA_W-1:0]   core_wdata [4];
    logic [1:0]          pick;
    logic                pick_valid;

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign core_addr[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
        assign core_wdata[gi] = i_wdata[gi*DATA_W +: DATA_W];
    end

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick       = 2'd0;
        pick_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (i_req[k]) begin
                pick       = 2'(k);
                pick_valid = 1'b1;
            end
        end
    end
`else
    logic [1:0] last_grant_reg, last_grant_next;

    // Scan from the farthest successor to the nearest so the nearest one wins.
    always_comb begin
        pick       = 2'd0;
        pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (i_req[2'(last_grant_reg + 2'(k))]) begin
                pick       = 2'(last_grant_reg + 2'(k));
                pick_valid = 1'b1;
            end
        end
    end

    assign last_grant_next = (state_reg == ACK) ? grant_reg : last_grant_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_reg <= 2'd3;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        we_next       = we_reg;
        cnt_next      = cnt_reg;
        ack_next      = 4'b0000;
        rdata_next    = rdata_reg;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;
        mem_rden_next = 1'b0;
        mem_wren_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // The DRAM address/data registers double as the request latch.
                if (pick_valid) begin
                    grant_next    = pick;
                    we_next       = i_we[pick];
                    mem_addr_next = core_addr[pick];
                    mem_data_next = core_wdata[pick];
                    mem_wren_next = i_we[pick];
                    mem_rden_next = ~i_we[pick];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    ack_next   = 4'(4'b0001 << grant_reg);
                    state_next = ACK;
                end else begin
                    cnt_next   = 3'(RD_LAT);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd1) begin
                    rdata_next = i_mem_q;
                    ack_next   = 4'(4'b0001 << grant_reg);
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            grant_reg    <= 2'd0;
            we_reg       <= 1'b0;
            cnt_reg      <= 3'd0;
            ack_reg      <= 4'b0000;
            rdata_reg    <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_rden_reg <= 1'b0;
            mem_wren_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            we_reg       <= we_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            rdata_reg    <= rdata_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
            mem_rden_reg <= mem_rden_next;
            mem_wren_reg <= mem_wren_next;
            busy_reg     <= busy_next;
        end
    end

    assign o_ack      = ack_reg;
    assign o_rdata    = rdata_reg;
    assign o_mem_addr = mem_addr_reg;
    assign o_mem_data = mem_data_reg;
    assign o_mem_rden = mem_rden_reg;
    assign o_mem_wren = mem_wren_reg;
    assign o_busy     = busy_reg;

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Bench for dram_request_arbiter: u0 runs with RD_LAT=1, u1 with RD_LAT=3, both on a shared DRAM model.
// Directed scenarios are followed by a randomized run checked against a transaction-level model.
module tb_dram_request_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clear = 1'b1;

    logic [3:0]  req0 = 4'b0, we0 = 4'b0;
    logic [63:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [3:0]  ack0;
    logic [7:0]  rdata0, mdata0, q0;
    logic [15:0] maddr0;
    logic        rden0, wren0, busy0;

    logic [3:0]  req1 = 4'b0, we1 = 4'b0;
    logic [63:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic [3:0]  ack1;
    logic [7:0]  rdata1, mdata1, q1;
    logic [15:0] maddr1;
    logic        rden1, wren1, busy1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dram_request_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(1)) u0 (
        .i_clk(clk), .i_rst(rst), .i_req(req0), .i_we(we0), .i_addr(addr0), .i_wdata(wdata0),
        .o_ack(ack0), .o_rdata(rdata0), .o_mem_addr(maddr0), .o_mem_data(mdata0),
        .o_mem_rden(rden0), .o_mem_wren(wren0), .i_mem_q(q0), .o_busy(busy0)
    );

    dram_request_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(3)) u1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we1), .i_addr(addr1), .i_wdata(wdata1),
        .o_ack(ack1), .o_rdata(rdata1), .o_mem_addr(maddr1), .o_mem_data(mdata1),
        .o_mem_rden(rden1), .o_mem_wren(wren1), .i_mem_q(q1), .o_busy(busy1)
    );

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h20) ? 8'h3C : (a ^ 8'h5A);
    endfunction

    // DRAM model: q is valid exactly RD_LAT cycles after the rden cycle, 8'hEE otherwise.
    logic [7:0] dram [256];
    logic [7:0] p0, p1a, p1b, p1c;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) dram[i] <= init_val(8'(i));
        end else begin
            if (wren0) dram[maddr0[7:0]] <= mdata0;
            if (wren1) dram[maddr1[7:0]] <= mdata1;
        end
        p0  <= rden0 ? dram[maddr0[7:0]] : 8'hEE;
        p1a <= rden1 ? dram[maddr1[7:0]] : 8'hEE;
        p1b <= p1a;
        p1c <= p1b;
    end
    assign q0 = p0;
    assign q1 = p1c;

    function automatic logic [1:0] model_pick(input logic [3:0] mask, input logic [1:0] last);
`ifdef ARB_FIXED_PRIO_EN
        for (int n = 0; n < 4; n++) if (mask[n]) return 2'(n);
`else
        for (int k = 1; k <= 4; k++) begin
            int n = (int'(last) + k) % 4;
            if (mask[n]) return 2'(n);
        end
`endif
        return 2'd0;
    endfunction

    task automatic set_core0(input int n, input logic w, input logic [15:0] a, input logic [7:0] d);
        we0[n] = w; addr0[n*16 +: 16] = a; wdata0[n*8 +: 8] = d;
    endtask

    task automatic set_core1(input int n, input logic w, input logic [15:0] a, input logic [7:0] d);
        we1[n] = w; addr1[n*16 +: 16] = a; wdata1[n*8 +: 8] = d;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Returns the number of negedges until u0 acks (-1 on timeout) and whether both strobes ever overlapped.
    task automatic wait_ack0(output int cycles, output logic [3:0] ackv, output bit overlap);
        cycles = 0; ackv = 4'b0; overlap = 1'b0;
        while (cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (rden0 && wren0) overlap = 1'b1;
            if (ack0 != 4'b0) begin
                ackv = ack0;
                break;
            end
        end
        if (ackv == 4'b0) cycles = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({ack0, rdata0, maddr0, mdata0, rden0, wren0, busy0} !== 39'b0) begin
            fails++; $display("FAIL reset_u0: got %h want 0", {ack0, rdata0, maddr0, mdata0, rden0, wren0, busy0});
        end
        tests++;
        if ({ack1, rdata1, maddr1, mdata1, rden1, wren1, busy1} !== 39'b0) begin
            fails++; $display("FAIL reset_u1: got %h want 0", {ack1, rdata1, maddr1, mdata1, rden1, wren1, busy1});
        end
        mem_clear = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({busy0, ack0} !== 5'b0) begin
            fails++; $display("FAIL reset_idle: busy/ack got %b want 0", {busy0, ack0});
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_single_write();
        int cyc; logic [3:0] a; bit ov;
        set_core0(0, 1'b1, 16'h0010, 8'hA5);
        req0 = 4'b0001;
        @(negedge clk);
        tests++;
        if ({wren0, rden0, busy0, maddr0, mdata0} !== {3'b101, 16'h0010, 8'hA5}) begin
            fails++; $display("FAIL write_issue: wren/rden/busy/addr/data got %b %b %b %h %h want 1 0 1 0010 a5",
                              wren0, rden0, busy0, maddr0, mdata0);
        end
        wait_ack0(cyc, a, ov);
        tests++;
        if (cyc !== 1 || a !== 4'b0001 || busy0 !== 1'b1 || wren0 !== 1'b0) begin
            fails++; $display("FAIL write_ack: cycles %0d ack %b busy %b wren %b want 1 0001 1 0", cyc, a, busy0, wren0);
        end
        req0 = 4'b0000;
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || ack0 !== 4'b0) begin
            fails++; $display("FAIL write_done: busy %b ack %b want 0 0000", busy0, ack0);
        end
        $display("[TB] single write core0 addr 0010 data a5 ack after %0d+1 cycles", cyc);
    endtask

    task automatic test_single_read();
        int cyc; logic [3:0] a; bit ov;
        set_core0(2, 1'b0, 16'h0020, 8'h00);
        req0 = 4'b0100;
        @(negedge clk);
        tests++;
        if ({rden0, wren0, maddr0} !== {2'b10, 16'h0020}) begin
            fails++; $display("FAIL read_issue: rden/wren/addr got %b %b %h want 1 0 0020", rden0, wren0, maddr0);
        end
        wait_ack0(cyc, a, ov);
        tests++;
        if (cyc !== 2 || a !== 4'b0100 || rdata0 !== 8'h3C) begin
            fails++; $display("FAIL read_ack: cycles %0d ack %b rdata %h want 2 0100 3c", cyc, a, rdata0);
        end
        req0 = 4'b0000;
        @(negedge clk);
        set_core0(1, 1'b1, 16'h0030, 8'h77);
        req0 = 4'b0010;
        wait_ack0(cyc, a, ov);
        req0 = 4'b0000;
        tests++;
        if (a !== 4'b0010 || rdata0 !== 8'h3C) begin
            fails++; $display("FAIL read_hold: ack %b rdata %h after write want 0010 3c", a, rdata0);
        end
        $display("[TB] single read core2 addr 0020 rdata %h", rdata0);
    endtask

    task automatic test_contention();
        int cyc; logic [3:0] a; bit ov;
        do_reset();
        for (int n = 0; n < 4; n++) set_core0(n, 1'b0, 16'h0020 + 16'(n), 8'h00);
        req0 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack0(cyc, a, ov);
            req0 = req0 & ~a;
            tests++;
            if (a !== 4'(4'b0001 << k) || cyc !== (k == 0 ? 3 : 4) || rdata0 !== init_val(8'h20 + 8'(k))) begin
                fails++; $display("FAIL contention_%0d: ack %b cycles %0d rdata %h want %b %0d %h", k, a, cyc, rdata0,
                                  4'(4'b0001 << k), (k == 0 ? 3 : 4), init_val(8'h20 + 8'(k)));
            end
            tests++;
            if (ov !== 1'b0) begin
                fails++; $display("FAIL contention_strobes_%0d: rden&wren overlap got 1 want 0", k);
            end
            $display("[TB] contention grant %0d ack %b", k, a);
        end
        req0 = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int cyc; logic [3:0] a; bit ov;
        set_core0(0, 1'b0, 16'h0024, 8'h00);
        set_core0(2, 1'b0, 16'h0026, 8'h00);
        req0 = 4'b0100;
        wait_ack0(cyc, a, ov);
        req0 = 4'b0000;
        @(negedge clk);
        req0 = 4'b0101;
        wait_ack0(cyc, a, ov);
        req0 = 4'b0100;
        tests++;
        if (a !== 4'b0001 || cyc !== 3) begin
            fails++; $display("FAIL fairness_first: ack %b cycles %0d want 0001 3", a, cyc);
        end
        wait_ack0(cyc, a, ov);
        req0 = 4'b0000;
        tests++;
        if (a !== 4'b0100 || cyc !== 4 || rdata0 !== init_val(8'h26)) begin
            fails++; $display("FAIL fairness_second: ack %b cycles %0d rdata %h want 0100 4 %h", a, cyc, rdata0, init_val(8'h26));
        end
        $display("[TB] fairness after core2: core0 then core2");
        @(negedge clk);
    endtask

    task automatic test_rdlat3();
        int cyc = 0;
        set_core1(1, 1'b0, 16'h0040, 8'h00);
        req1 = 4'b0010;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                tests++;
                if ({rden1, wren1, maddr1} !== {2'b10, 16'h0040}) begin
                    fails++; $display("FAIL rdlat3_issue: rden/wren/addr %b %b %h want 1 0 0040", rden1, wren1, maddr1);
                end
            end
        end while (ack1 == 4'b0 && cyc < 40);
        req1 = 4'b0000;
        tests++;
        if (ack1 !== 4'b0010 || cyc !== 5 || rdata1 !== init_val(8'h40)) begin
            fails++; $display("FAIL rdlat3_ack: ack %b cycles %0d rdata %h want 0010 5 %h", ack1, cyc, rdata1, init_val(8'h40));
        end
        $display("[TB] rd_lat=3 read core1 ack after %0d cycles rdata %h", cyc, rdata1);
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        int cyc;
        set_core1(0, 1'b0, 16'h0041, 8'h00);
        set_core1(2, 1'b0, 16'h0042, 8'h00);
        req1 = 4'b0101;
        repeat (3) @(negedge clk);
        tests++;
        if (busy1 !== 1'b1 || rden1 !== 1'b0) begin
            fails++; $display("FAIL rstwait_pre: busy %b rden %b want 1 0", busy1, rden1);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({ack1, rden1, wren1, busy1, rdata1, maddr1, mdata1} !== 39'b0) begin
            fails++; $display("FAIL rstwait_async: got %h want 0", {ack1, rden1, wren1, busy1, rdata1, maddr1, mdata1});
        end
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack1 == 4'b0 && cyc < 40);
        req1 = 4'b0100;
        tests++;
        if (ack1 !== 4'b0001 || cyc !== 5 || rdata1 !== init_val(8'h41)) begin
            fails++; $display("FAIL rstwait_first: ack %b cycles %0d rdata %h want 0001 5 %h", ack1, cyc, rdata1, init_val(8'h41));
        end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (ack1 == 4'b0 && cyc < 40);
        req1 = 4'b0000;
        tests++;
        if (ack1 !== 4'b0100 || cyc !== 6 || rdata1 !== init_val(8'h42)) begin
            fails++; $display("FAIL rstwait_second: ack %b cycles %0d rdata %h want 0100 6 %h", ack1, cyc, rdata1, init_val(8'h42));
        end
        $display("[TB] reset during wait aborted, core0 served first after release");
    endtask

    task automatic test_random();
        int          issue_at = -10, ack_at = -10, grants = 0;
        logic [1:0]  g = 2'd0, last = 2'd3;
        logic        g_we = 1'b0;
        logic [15:0] g_addr = '0;
        logic [7:0]  g_data = '0, g_q = '0, exp_rdata = '0;
        logic [7:0]  shadow [256];
        logic        pend [4], pwe [4];
        logic [15:0] pa [4];
        logic [7:0]  pd [4];
        logic [3:0]  exp_ack, mask;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
        for (int n = 0; n < 4; n++) begin pend[n] = 1'b0; pwe[n] = 1'b0; pa[n] = '0; pd[n] = '0; end
        req0 = 4'b0000;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            exp_ack = (c == ack_at) ? 4'(4'b0001 << g) : 4'b0000;
            tests++;
            if (ack0 !== exp_ack) begin
                fails++; $display("FAIL rand_ack c=%0d: got %b want %b", c, ack0, exp_ack);
            end
            tests++;
            if (busy0 !== (c >= issue_at && c <= ack_at)) begin
                fails++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy0, (c >= issue_at && c <= ack_at));
            end
            tests++;
            if ({rden0, wren0} !== {(c == issue_at) && !g_we, (c == issue_at) && g_we}) begin
                fails++; $display("FAIL rand_strobe c=%0d: rden/wren got %b%b want %b%b", c, rden0, wren0,
                                  (c == issue_at) && !g_we, (c == issue_at) && g_we);
            end
            if (c == issue_at) begin
                tests++;
                if (maddr0 !== g_addr || (g_we && mdata0 !== g_data)) begin
                    fails++; $display("FAIL rand_issue c=%0d: addr/data got %h %h want %h %h", c, maddr0, mdata0, g_addr, g_data);
                end
            end
            if (c == ack_at && !g_we) exp_rdata = g_q;
            tests++;
            if (rdata0 !== exp_rdata) begin
                fails++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, rdata0, exp_rdata);
            end
            if (c == ack_at) $display("[TB] rand txn core%0d we=%b addr %h data %h", g, g_we, g_addr, g_we ? g_data : g_q);
            for (int n = 0; n < 4; n++) begin
                if (c == ack_at && g == 2'(n)) begin
                    pend[n] = 1'b0;
                end else if (!pend[n]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pend[n] = 1'b1;
                        pwe[n]  = 1'($urandom_range(0, 1));
                        pa[n]   = 16'h0080 + 16'($urandom_range(0, 7));
                        pd[n]   = 8'($urandom);
                    end
                end else if (!(c >= issue_at - 1 && c <= ack_at && g == 2'(n)) && $urandom_range(0, 15) == 0) begin
                    pend[n] = 1'b0;
                end
                mask[n] = pend[n];
                set_core0(n, pwe[n], pa[n], pd[n]);
            end
            req0 = mask;
            if (c > ack_at && mask != 4'b0) begin
                g        = model_pick(mask, last);
                last     = g;
                g_we     = pwe[g];
                g_addr   = pa[g];
                g_data   = pd[g];
                issue_at = c + 1;
                grants++;
                if (g_we) begin
                    shadow[g_addr[7:0]] = g_data;
                    ack_at = c + 2;
                end else begin
                    g_q    = shadow[g_addr[7:0]];
                    ack_at = c + 3;
                end
            end
        end
        req0 = 4'b0000;
        $display("[TB] random run issued %0d grants", grants);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_fairness();
        test_rdlat3();
        test_reset_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
